imem_dmem_arbiter: RTL and testbench

Shares a single-ported, synchronous-read 256-word memory between the fetch stage (instruction port, read-only) and the MEM stage (data port, read/write) of the 5-stage MIPS pipeline.
Arbitration is fixed-priority, with data ahead of fetch, plus a starvation guard that forces a fetch grant after a set number of losses.
Every transaction uses a two-cycle issue/response sequence.
The block provides per-port stall signals that the pipeline control uses to freeze the fetch stage and the MEM stage.

---
 rtl/mips_pkg.sv | 17 +
 rtl/arb_prio_starve.sv | 42 ++++
 rtl/imem_dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the instruction/data memory arbiter of the 5-stage MIPS pipeline.
package mips_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned WAIT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_prio_starve.sv
// Fixed data-over-fetch priority with a fetch starvation guard.
module arb_prio_starve
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_c,
    output logic grant_own_c
);

    logic [WAIT_W-1:0] wait_cnt;
    logic              force_i_c;

    // Fetch wins outright once it has lost MAX_WAIT consecutive arbitrations.
    always_comb begin
        force_i_c   = i_req && (wait_cnt >= WAIT_W'(MAX_WAIT));
        grant_c     = i_req || d_req;
        grant_own_c = OWN_I;
        if (!force_i_c && d_req) begin
            grant_own_c = OWN_D;
        end
    end

    // Counts only arbitrations that fetch loses while asking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (arb_en) begin
            if (!i_req || (grant_own_c == OWN_I)) begin
                wait_cnt <= '0;
            end else if (wait_cnt != {WAIT_W{1'b1}}) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one synchronous-read memory between the fetch and MEM stages using
// a two-cycle issue/response sequence per transaction.
module imem_dmem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MEM_AW    = 8,
    parameter int unsigned MAX_WAIT  = 3,
    parameter int unsigned BYTE_ADDR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_redata,
    output logic              stall_if,
    output logic              stall_mem
);

    state_t            state, state_nxt;
    logic              owner, owner_nxt;
    logic              we_q, we_nxt;
    logic              arb_en_c, grant_c, grant_own_c;
    logic              i_gnt_nxt, d_gnt_nxt, i_rvalid_nxt, d_rvalid_nxt;
    logic              mem_write_nxt, mem_read_nxt;
    logic [MEM_AW-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wrdata_nxt;

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return (BYTE_ADDR != 0) ? MEM_AW'(a >> 2) : MEM_AW'(a);
    endfunction

    arb_prio_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_en      (arb_en_c),
        .i_req       (i_req),
        .d_req       (d_req),
        .grant_c     (grant_c),
        .grant_own_c (grant_own_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= OWN_I;
            we_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            we_q  <= we_nxt;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        we_nxt         = we_q;
        arb_en_c       = 1'b0;
        i_gnt_nxt      = 1'b0;
        d_gnt_nxt      = 1'b0;
        i_rvalid_nxt   = 1'b0;
        d_rvalid_nxt   = 1'b0;
        mem_write_nxt  = 1'b0;
        mem_read_nxt   = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_wrdata_nxt = '0;
        case (state)
            IDLE, RESP: begin
                arb_en_c  = 1'b1;
                state_nxt = IDLE;
                if (grant_c) begin
                    state_nxt = ISSUE;
                    owner_nxt = grant_own_c;
                    if (grant_own_c == OWN_D) begin
                        we_nxt         = d_we;
                        d_gnt_nxt      = 1'b1;
                        mem_addr_nxt   = word_idx(d_addr);
                        mem_write_nxt  = d_we;
                        mem_read_nxt   = ~d_we;
                        mem_wrdata_nxt = d_we ? d_wdata : '0;
                    end else begin
                        we_nxt       = 1'b0;
                        i_gnt_nxt    = 1'b1;
                        mem_addr_nxt = word_idx(i_addr);
                        mem_read_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nxt    = RESP;
                i_rvalid_nxt = (owner == OWN_I) && !we_q;
                d_rvalid_nxt = (owner == OWN_D) && !we_q;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            mem_wrdata <= '0;
        end else begin
            i_gnt      <= i_gnt_nxt;
            d_gnt      <= d_gnt_nxt;
            i_rvalid   <= i_rvalid_nxt;
            d_rvalid   <= d_rvalid_nxt;
            mem_write  <= mem_write_nxt;
            mem_read   <= mem_read_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wrdata <= mem_wrdata_nxt;
        end
    end

    // Read data is forwarded straight from memory during the response cycle.
    assign i_rdata   = i_rvalid ? mem_redata : '0;
    assign d_rdata   = d_rvalid ? mem_redata : '0;
    assign stall_if  = i_req & ~i_rvalid;
    assign stall_mem = d_req & ~d_rvalid & ~(d_gnt & d_we);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a behavioural synchronous-read memory.
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wrdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_redata;
    logic        stall_if;
    logic        stall_mem;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [256];

    imem_dmem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_AW    (8),
        .MAX_WAIT  (3),
        .BYTE_ADDR (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_addr   (mem_addr),
        .mem_wrdata (mem_wrdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_redata (mem_redata),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'(k);
        mem_redata = '0;
    end

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wrdata;
        if (mem_read)  mem_redata    <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    logic exp_d [8];
    logic [3:0] exp_w [8];

    initial begin
        rst_n = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_i_gnt", 32'(i_gnt), 0);
        check("rst_d_gnt", 32'(d_gnt), 0);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        rst_n = 1'b1;
        step();

        // Single fetch from 0x8
        i_req = 1; i_addr = 32'h8;
        #1 check("t1_stall_if_rise", 32'(stall_if), 1);
        step();
        check("t1_i_gnt", 32'(i_gnt), 1);
        check("t1_mem_addr", 32'(mem_addr), 2);
        check("t1_mem_read", 32'(mem_read), 1);
        check("t1_stall_if_gnt", 32'(stall_if), 1);
        step();
        check("t1_i_rvalid", 32'(i_rvalid), 1);
        check("t1_i_rdata", i_rdata, 2);
        check("t1_d_rdata_zero", d_rdata, 0);
        check("t1_stall_if_rv", 32'(stall_if), 0);
        check("t1_i_gnt_low", 32'(i_gnt), 0);
        i_req = 0;
        step();

        // Store 0xAB to 0x10, then load it back
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hAB;
        step();
        check("t2_st_d_gnt", 32'(d_gnt), 1);
        check("t2_st_mem_write", 32'(mem_write), 1);
        check("t2_st_mem_read", 32'(mem_read), 0);
        check("t2_st_mem_addr", 32'(mem_addr), 4);
        check("t2_st_wrdata", mem_wrdata, 32'hAB);
        check("t2_st_stall_mem", 32'(stall_mem), 0);
        d_we = 0; d_wdata = 0;
        step();
        check("t2_st_no_rvalid", 32'(d_rvalid), 0);
        check("t2_st_d_rdata", d_rdata, 0);
        step();
        check("t2_ld_d_gnt", 32'(d_gnt), 1);
        check("t2_ld_mem_read", 32'(mem_read), 1);
        check("t2_ld_mem_addr", 32'(mem_addr), 4);
        check("t2_ld_wrdata_zero", mem_wrdata, 0);
        check("t2_ld_stall_mem", 32'(stall_mem), 1);
        d_req = 0;
        step();
        check("t2_ld_d_rvalid", 32'(d_rvalid), 1);
        check("t2_ld_d_rdata", d_rdata, 32'hAB);
        step();

        // Both ports requesting continuously: starvation guard
        exp_d = '{1, 1, 1, 0, 1, 1, 1, 0};
        exp_w = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        i_req = 1; i_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h0;
        for (int g = 0; g < 8; g++) begin
            step();
            check($sformatf("t3_d_gnt_%0d", g), 32'(d_gnt), 32'(exp_d[g]));
            check($sformatf("t3_i_gnt_%0d", g), 32'(i_gnt), 32'(!exp_d[g]));
            check($sformatf("t3_wait_%0d", g), 32'(dut.u_arb.wait_cnt), 32'(exp_w[g]));
            step();
            check($sformatf("t3_rvalid_%0d", g), 32'(exp_d[g] ? d_rvalid : i_rvalid), 1);
        end
        i_req = 0; d_req = 0;
        step();
        check("t3_idle", 32'(i_gnt | d_gnt), 0);

        // Back-to-back loads from 0x0 and 0x4
        d_req = 1; d_we = 0; d_addr = 32'h0;
        step();
        check("t4_gnt0", 32'(d_gnt), 1);
        check("t4_addr0", 32'(mem_addr), 0);
        d_addr = 32'h4;
        step();
        check("t4_rvalid0", 32'(d_rvalid), 1);
        check("t4_rdata0", d_rdata, 0);
        check("t4_resp_read0", 32'(mem_read), 0);
        check("t4_resp_gnt0", 32'(d_gnt), 0);
        step();
        check("t4_gnt1", 32'(d_gnt), 1);
        check("t4_addr1", 32'(mem_addr), 1);
        d_req = 0;
        step();
        check("t4_rvalid1", 32'(d_rvalid), 1);
        check("t4_rdata1", d_rdata, 1);
        check("t4_resp_read1", 32'(mem_read), 0);
        step();

        // Reset asserted during a fetch issue cycle
        i_req = 1; i_addr = 32'hC;
        step();
        check("t5_i_gnt", 32'(i_gnt), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_gnt", 32'(i_gnt), 0);
        check("t5_async_read", 32'(mem_read), 0);
        check("t5_async_addr", 32'(mem_addr), 0);
        step();
        check("t5_no_rvalid", 32'(i_rvalid), 0);
        rst_n = 1'b1;
        step();
        check("t5_regnt", 32'(i_gnt), 1);
        check("t5_regnt_addr", 32'(mem_addr), 3);
        step();
        check("t5_rvalid", 32'(i_rvalid), 1);
        check("t5_rdata", i_rdata, 3);
        i_req = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
